// File: rtl/kwta_inhibit_gen_if.sv
// kwta_inhibit_gen_if
// Bundles the gamma-reset/spike inputs and the inhibit/winner outputs of the
// k-WTA inhibit generator.
//   grst        : 1-cycle gamma reset pulse (start of a gamma cycle)
//   spike_in    : N spike lines, edge or pulse coded
//   inhibit_out : 0->1 inhibit edge, held until grst/rst
//   win_valid   : 1-cycle pulse when inhibit first rises
//   win_mask    : lines counted as winners
//   win_time    : unit time of the K-th arrival, all-ones when none
// master = stimulus side, slave = generator side.
interface kwta_inhibit_gen_if #(
    parameter int N  = 8,
    parameter int TW = 4
);
    logic          grst;
    logic [N-1:0]  spike_in;
    logic          inhibit_out;
    logic          win_valid;
    logic [N-1:0]  win_mask;
    logic [TW-1:0] win_time;

    modport master (
        output grst, spike_in,
        input  inhibit_out, win_valid, win_mask, win_time
    );

    modport slave (
        input  grst, spike_in,
        output inhibit_out, win_valid, win_mask, win_time
    );
endinterface

// File: rtl/kwta_inhibit_gen.sv
// kwta_inhibit_gen
// k-winner-take-all inhibit generator for a race-logic column. Counts distinct
// spike lines arriving in one gamma cycle; once K have arrived it raises a held
// inhibit edge, reports the winning lines and the unit time of the K-th arrival.
// Ports:
//   clk  : unit clock
//   rst  : synchronous active-high reset (priority over grst)
//   bus  : kwta_inhibit_gen_if.slave (grst, spike_in in; inhibit/win_* out)
// All outputs are registered.

// Per-line edge detector: a line contributes one rise per gamma cycle.
module kwta_lane (
    input  logic clk,
    input  logic rst,
    input  logic clr,     // gamma reset: discards this cycle's spike
    input  logic frz,     // inhibit already high: stop capturing arrivals
    input  logic spike,
    output logic rise,
    output logic seen
);
    logic prev;

    assign rise = spike & ~prev & ~seen;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev <= 1'b0;
            seen <= 1'b0;
        end else begin
            prev <= spike;
            if (!frz && rise)
                seen <= 1'b1;
        end
    end
endmodule

module kwta_inhibit_gen #(
    parameter int N  = 8,
    parameter int K  = 1,
    parameter int TW = 4
) (
    input  logic               clk,
    input  logic               rst,
    kwta_inhibit_gen_if.slave  bus
);
    // count + popcount(rise) can reach 2N, one bit wider than popcount alone
    localparam int PW = $clog2(N + 1);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] TMAX = {TW{1'b1}};

    generate
        if (K < 1 || K > N) begin : g_bad_k
            $error("kwta_inhibit_gen: K must be in 1..N");
        end
    endgenerate

    logic [N-1:0]  rise;
    logic [N-1:0]  seen;
    logic          inh_q;
    logic          win_valid_q;
    logic [N-1:0]  win_mask_q;
    logic [TW-1:0] win_time_q;
    logic [TW-1:0] t_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] sum;
    logic          fire;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            kwta_lane u_lane (
                .clk   (clk),
                .rst   (rst),
                .clr   (bus.grst),
                .frz   (inh_q),
                .spike (bus.spike_in[gi]),
                .rise  (rise[gi]),
                .seen  (seen[gi])
            );
        end
    endgenerate

    function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++)
            s = s + CW'(v[i]);
        return s;
    endfunction

    assign sum  = count_q + popcnt(rise);
    // grst is handled by the reset branch below, so it also suppresses a
    // coincident fire.
    assign fire = ~inh_q & (sum >= CW'(K));

    always_ff @(posedge clk) begin
        if (rst || bus.grst) begin
            inh_q       <= 1'b0;
            win_valid_q <= 1'b0;
            win_mask_q  <= '0;
            win_time_q  <= TMAX;
            t_q         <= '0;
            count_q     <= '0;
        end else begin
            win_valid_q <= 1'b0;
            // time keeps running after inhibit; saturates at the null code
            if (t_q != TMAX)
                t_q <= t_q + 1'b1;
            if (!inh_q) begin
                count_q <= fire ? CW'(K) : sum;
                if (fire) begin
                    inh_q       <= 1'b1;
                    win_valid_q <= 1'b1;
                    win_mask_q  <= seen | rise;  // ties in the firing cycle all win
                    win_time_q  <= t_q;
                end
            end
        end
    end

    assign bus.inhibit_out = inh_q;
    assign bus.win_valid   = win_valid_q;
    assign bus.win_mask    = win_mask_q;
    assign bus.win_time    = win_time_q;
endmodule

// File: tb/tb_kwta_inhibit_gen.sv
// Bench for kwta_inhibit_gen: two instances (K=2, K=1) share stimulus.
// A reference model based on per-gamma-cycle arrival sets predicts each fire
// and pushes it into a per-instance queue; a negedge monitor pops on win_valid.
module tb_kwta_inhibit_gen;
    localparam int N  = 8;
    localparam int TW = 4;

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [TW-1:0] tm;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic grst_d = 1'b0;
    logic [N-1:0] spike_d = '0;
    always #5 clk = ~clk;

    kwta_inhibit_gen_if #(.N(N), .TW(TW)) bus0 ();
    kwta_inhibit_gen_if #(.N(N), .TW(TW)) bus1 ();
    assign bus0.grst = grst_d;
    assign bus0.spike_in = spike_d;
    assign bus1.grst = grst_d;
    assign bus1.spike_in = spike_d;

    kwta_inhibit_gen #(.N(N), .K(2), .TW(TW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    kwta_inhibit_gen #(.N(N), .K(1), .TW(TW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    // Reference model: which lines have arrived this gamma cycle, how many
    // cycles since the gamma reset, and whether each instance has fired.
    int           kval [2] = '{2, 1};
    int           gc;
    logic [N-1:0] prevs;
    logic [N-1:0] arrived;
    bit           fired  [2];
    bit           evalid [2];
    logic [N-1:0] emask  [2];
    logic [TW-1:0] etime [2];
    win_t q0[$];
    win_t q1[$];

    task automatic model_update(input logic g, input logic r, input logic [N-1:0] s);
        win_t w;
        for (int m = 0; m < 2; m++) evalid[m] = 1'b0;
        if (r || g) begin
            gc = 0; prevs = '0; arrived = '0;
            for (int m = 0; m < 2; m++) begin
                fired[m] = 1'b0; emask[m] = '0; etime[m] = '1;
            end
        end else begin
            arrived = arrived | (s & ~prevs);
            prevs = s;
            for (int m = 0; m < 2; m++) begin
                if (!fired[m] && $countones(arrived) >= kval[m]) begin
                    fired[m] = 1'b1; evalid[m] = 1'b1;
                    emask[m] = arrived;
                    etime[m] = (gc > 15) ? 4'hF : gc[TW-1:0];
                    w.mask = arrived; w.tm = etime[m];
                    if (m == 0) q0.push_back(w); else q1.push_back(w);
                end
            end
            gc++;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon_one(input int m, input logic inh, input logic vld,
                           input logic [N-1:0] mask, input logic [TW-1:0] tm);
        win_t w;
        chk($sformatf("inhibit[k%0d]", kval[m]), int'(inh), int'(fired[m]));
        chk($sformatf("valid[k%0d]", kval[m]), int'(vld), int'(evalid[m]));
        chk($sformatf("mask[k%0d]", kval[m]), int'(mask), int'(emask[m]));
        chk($sformatf("time[k%0d]", kval[m]), int'(tm), int'(etime[m]));
        if (vld) begin
            if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                chk($sformatf("unexpected_win[k%0d]", kval[m]), 1, 0);
            end else begin
                w = (m == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("sb_mask[k%0d]", kval[m]), int'(mask), int'(w.mask));
                chk($sformatf("sb_time[k%0d]", kval[m]), int'(tm), int'(w.tm));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_one(0, bus0.inhibit_out, bus0.win_valid, bus0.win_mask, bus0.win_time);
            mon_one(1, bus1.inhibit_out, bus1.win_valid, bus1.win_mask, bus1.win_time);
        end
    end

    task automatic cyc(input logic g, input logic r, input logic [N-1:0] s);
        grst_d = g; rst = r; spike_d = s;
        @(posedge clk);
        model_update(g, r, s);
        #1;
    endtask

    initial begin
        logic [N-1:0] s;
        // 1. reset with random spikes
        cyc(1'b0, 1'b1, N'($urandom));
        cyc(1'b0, 1'b1, N'($urandom));
        mon_on = 1'b1;
        chk("rst_inh", int'(bus0.inhibit_out), 0);
        chk("rst_vld", int'(bus0.win_valid), 0);
        chk("rst_mask", int'(bus0.win_mask), 8'h00);
        chk("rst_time", int'(bus0.win_time), 4'hF);

        // 2. basic: line3 @t2, line5 @t4, line1 @t6
        cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);                  // t0,t1
        cyc(0, 0, 8'h08); cyc(0, 0, 8'h08);                  // t2,t3
        cyc(0, 0, 8'h28);                                     // t4
        chk("basic_inh_t5", int'(bus0.inhibit_out), 1);
        chk("basic_vld_t5", int'(bus0.win_valid), 1);
        chk("basic_mask", int'(bus0.win_mask), 8'h28);
        chk("basic_time", int'(bus0.win_time), 4);
        cyc(0, 0, 8'h28);                                     // t5
        cyc(0, 0, 8'h2A);                                     // t6 late line1
        cyc(0, 0, 8'h2A);
        chk("basic_vld_once", int'(bus0.win_valid), 0);
        chk("basic_late_mask", int'(bus0.win_mask), 8'h28);

        // 5. mid-cycle gamma reset with line4 high in grst cycle
        cyc(1, 0, 8'h10);
        chk("grst_clear_inh", int'(bus0.inhibit_out), 0);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h40); cyc(0, 0, 8'hC0);  // t0,t1,t2
        chk("regrst_mask", int'(bus0.win_mask), 8'hC0);
        chk("regrst_time", int'(bus0.win_time), 2);
        cyc(0, 0, 8'hC0);

        // 3. tie: lines 0..2 at t3
        cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h07);                                     // t3
        chk("tie_mask_k2", int'(bus0.win_mask), 8'h07);
        chk("tie_time_k2", int'(bus0.win_time), 3);
        chk("tie_mask_k1", int'(bus1.win_mask), 8'h07);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);

        // 4. re-pulse on line 2 only; then saturation run
        cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h04); cyc(0, 0, 8'h00); cyc(0, 0, 8'h04);
        for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00);
        chk("insuf_inh", int'(bus0.inhibit_out), 0);
        chk("insuf_mask", int'(bus0.win_mask), 8'h00);
        chk("insuf_time", int'(bus0.win_time), 4'hF);
        cyc(1, 0, 8'h00);
        for (int i = 0; i < 20; i++) cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h81);                                     // t20: must read 15, not wrap
        chk("sat_time", int'(bus0.win_time), 4'hF);
        chk("sat_mask", int'(bus0.win_mask), 8'h81);

        // 6. rst with grst in the cycle of the K-th spike
        cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h01);
        cyc(1, 1, 8'h03);
        chk("prio_vld", int'(bus0.win_valid), 0);
        chk("prio_inh", int'(bus0.inhibit_out), 0);
        cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h10); cyc(0, 0, 8'h30);
        chk("prio_after_mask", int'(bus0.win_mask), 8'h30);
        chk("prio_after_time", int'(bus0.win_time), 1);

        // random gamma cycles
        for (int g = 0; g < 12; g++) begin
            s = N'($urandom);
            cyc(1, 0, s);
            for (int c = 0; c < 22; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 5) == 0) s[i] = ~s[i];
                case ($urandom_range(0, 59))
                    0:       cyc(0, 1, s);
                    1:       cyc(1, 0, s);
                    default: cyc(0, 0, s);
                endcase
            end
        end
        cyc(0, 0, 8'h00);
        @(negedge clk); #1;
        mon_on = 1'b0;
        chk("sb_drain_k2", q0.size(), 0);
        chk("sb_drain_k1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
